// File: rtl/ahci_afi_rd_responder_pkg.sv
// Shared AFI encodings and the sideband tag carried alongside each read beat.
package ahci_afi_rd_responder_pkg;

    localparam logic [1:0] AFI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AFI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AFI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AFI_SIZE_64     = 2'b11;

    typedef struct packed {
        logic       last;
        logic [5:0] id;
        logic [1:0] resp;
    } rd_tag_t;

    function automatic logic ar_is_err(input logic [1:0] size, input logic [1:0] burst);
        return (size != AFI_SIZE_64) || (burst != AFI_BURST_INCR);
    endfunction

endpackage

// File: rtl/afi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module afi_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_dout,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_BITS:0]   o_count
);

    localparam logic [DEPTH_BITS-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_BITS:0]   CNT_ONE = 1;

    logic [WIDTH-1:0]      r_mem [2**DEPTH_BITS];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = r_count[DEPTH_BITS];
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/ahci_afi_rd_responder.sv
// AXI_HP read-channel responder: address FIFO -> burst engine -> memory model -> data FIFO.
// state   | meaning
// S_IDLE  | waiting for a queued address while rd_stall is low
// S_BURST | issuing one memory read per cycle while the data FIFO has room
module ahci_afi_rd_responder
    import ahci_afi_rd_responder_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 9,
    parameter int ARQ_BITS      = 2,
    parameter int RQ_BITS       = 7
) (
    input  logic                     hclk,
    input  logic                     hrst,
    input  logic [31:0]              afi_araddr,
    input  logic                     afi_arvalid,
    output logic                     afi_arready,
    input  logic [5:0]               afi_arid,
    input  logic [3:0]               afi_arlen,
    input  logic [1:0]               afi_arsize,
    input  logic [1:0]               afi_arburst,
    output logic [63:0]              afi_rdata,
    output logic                     afi_rvalid,
    input  logic                     afi_rready,
    output logic [5:0]               afi_rid,
    output logic                     afi_rlast,
    output logic [1:0]               afi_rresp,
    output logic [RQ_BITS:0]         afi_rcount,
    output logic [ARQ_BITS:0]        afi_racount,
    input  logic                     afi_rdissuecap1en,
    input  logic                     rd_stall,
    input  logic                     mem_we,
    input  logic [MEM_ADDR_BITS-1:0] mem_waddr,
    input  logic [63:0]              mem_wdata
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;
    localparam int AR_W  = MEM_ADDR_BITS + 4 + 6 + 1;
    localparam int RD_W  = 64 + $bits(rd_tag_t);
    localparam int CNT_W = RQ_BITS + 2;
    localparam logic [MEM_ADDR_BITS-1:0] ADDR_ONE = 1;

    logic [AR_W-1:0]          w_ar_din;
    logic [AR_W-1:0]          w_ar_dout;
    logic                     w_ar_empty;
    logic                     w_ar_full;
    logic                     w_ar_pop;
    logic [MEM_ADDR_BITS-1:0] w_ar_addr;
    logic [3:0]               w_ar_len;
    logic [5:0]               w_ar_id;
    logic                     w_ar_err;

    logic [0:0]               r_state;
    logic [MEM_ADDR_BITS-1:0] r_addr;
    logic [3:0]               r_beats_left;
    logic [5:0]               r_id;
    logic                     r_err;
    logic                     w_issue;
    logic                     w_room;
    logic [CNT_W-1:0]         w_pending;

    logic [63:0]              r_mem [2**MEM_ADDR_BITS];
    logic [63:0]              r_rd_data;
    logic                     r_rd_valid;
    rd_tag_t                  r_rd_tag;

    logic [RD_W-1:0]          w_rd_dout;
    logic                     w_rd_empty;
    logic                     w_rd_full;
    logic [RQ_BITS:0]         w_rcount;
    rd_tag_t                  w_rd_tag;
    logic                     w_unused;

    assign w_unused = &{1'b0, afi_rdissuecap1en, afi_araddr[31:MEM_ADDR_BITS+3],
                        afi_araddr[2:0], w_rd_full};

    assign w_ar_din = {afi_araddr[MEM_ADDR_BITS+2:3], afi_arlen, afi_arid,
                       ar_is_err(afi_arsize, afi_arburst)};
    assign {w_ar_addr, w_ar_len, w_ar_id, w_ar_err} = w_ar_dout;
    assign afi_arready = !w_ar_full;

    afi_sync_fifo #(.WIDTH(AR_W), .DEPTH_BITS(ARQ_BITS)) u_ar_fifo (
        .clk     (hclk),
        .rst     (hrst),
        .i_push  (afi_arvalid),
        .i_din   (w_ar_din),
        .i_pop   (w_ar_pop),
        .o_dout  (w_ar_dout),
        .o_empty (w_ar_empty),
        .o_full  (w_ar_full),
        .o_count (afi_racount)
    );

    // A read in flight already owns a data FIFO slot even though rcount has not seen it.
    assign w_pending = {1'b0, w_rcount} + CNT_W'(r_rd_valid);
    assign w_room    = w_pending < CNT_W'(32'd1 << RQ_BITS);
    assign w_ar_pop  = (r_state == S_IDLE) && !w_ar_empty && !rd_stall;
    assign w_issue   = (r_state == S_BURST) && w_room;

    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_id         <= '0;
            r_err        <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_tag     <= '0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_tag.last <= (r_beats_left == 4'd0);
                r_rd_tag.id   <= r_id;
                r_rd_tag.resp <= r_err ? AFI_RESP_SLVERR : AFI_RESP_OKAY;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_ar_pop) begin
                        r_addr       <= w_ar_addr;
                        r_beats_left <= w_ar_len;
                        r_id         <= w_ar_id;
                        r_err        <= w_ar_err;
                        r_state      <= S_BURST;
                    end
                end
                default: begin
                    if (w_issue) begin
                        if (r_beats_left == 4'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_beats_left <= r_beats_left - 4'd1;
                            r_addr       <= r_addr + ADDR_ONE;
                        end
                    end
                end
            endcase
        end
    end

    // Memory contents survive reset; a same-cycle backdoor write is seen by the read as old data.
    always_ff @(posedge hclk) begin
        if (mem_we)  r_mem[mem_waddr] <= mem_wdata;
        if (w_issue) r_rd_data <= r_mem[r_addr];
    end

    afi_sync_fifo #(.WIDTH(RD_W), .DEPTH_BITS(RQ_BITS)) u_rd_fifo (
        .clk     (hclk),
        .rst     (hrst),
        .i_push  (r_rd_valid),
        .i_din   ({r_rd_data, r_rd_tag}),
        .i_pop   (afi_rready),
        .o_dout  (w_rd_dout),
        .o_empty (w_rd_empty),
        .o_full  (w_rd_full),
        .o_count (w_rcount)
    );

    assign w_rd_tag   = w_rd_dout[$bits(rd_tag_t)-1:0];
    assign afi_rvalid = !w_rd_empty;
    assign afi_rdata  = w_rd_empty ? 64'd0 : w_rd_dout[RD_W-1:$bits(rd_tag_t)];
    assign afi_rid    = w_rd_empty ? 6'd0 : w_rd_tag.id;
    assign afi_rlast  = !w_rd_empty && w_rd_tag.last;
    assign afi_rresp  = w_rd_empty ? 2'd0 : w_rd_tag.resp;
    assign afi_rcount = w_rcount;

endmodule

// File: tb/tb_ahci_afi_rd_responder.sv
// Scoreboard bench: address issue pushes expected beats, a negedge monitor pops and compares.
module tb_ahci_afi_rd_responder;

    typedef struct packed {
        logic [63:0] data;
        logic [5:0]  id;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    logic        hclk = 1'b0;
    logic        hrst = 1'b1;
    logic [31:0] afi_araddr = '0;
    logic        afi_arvalid = 1'b0;
    logic        afi_arready;
    logic [5:0]  afi_arid = '0;
    logic [3:0]  afi_arlen = '0;
    logic [1:0]  afi_arsize = 2'b11;
    logic [1:0]  afi_arburst = 2'b01;
    logic [63:0] afi_rdata;
    logic        afi_rvalid;
    logic        afi_rready = 1'b1;
    logic [5:0]  afi_rid;
    logic        afi_rlast;
    logic [1:0]  afi_rresp;
    logic [7:0]  afi_rcount;
    logic [2:0]  afi_racount;
    logic        rd_stall = 1'b0;
    logic        mem_we = 1'b0;
    logic [8:0]  mem_waddr = '0;
    logic [63:0] mem_wdata = '0;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];

    always #5 hclk = ~hclk;

    ahci_afi_rd_responder dut (
        .hclk              (hclk),
        .hrst              (hrst),
        .afi_araddr        (afi_araddr),
        .afi_arvalid       (afi_arvalid),
        .afi_arready       (afi_arready),
        .afi_arid          (afi_arid),
        .afi_arlen         (afi_arlen),
        .afi_arsize        (afi_arsize),
        .afi_arburst       (afi_arburst),
        .afi_rdata         (afi_rdata),
        .afi_rvalid        (afi_rvalid),
        .afi_rready        (afi_rready),
        .afi_rid           (afi_rid),
        .afi_rlast         (afi_rlast),
        .afi_rresp         (afi_rresp),
        .afi_rcount        (afi_rcount),
        .afi_racount       (afi_racount),
        .afi_rdissuecap1en (1'b0),
        .rd_stall          (rd_stall),
        .mem_we            (mem_we),
        .mem_waddr         (mem_waddr),
        .mem_wdata         (mem_wdata)
    );

    function automatic logic [63:0] pat(input int i);
        return {32'h5A5A_0000 + 32'(i), 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge hclk) begin
        if (!hrst && afi_rvalid && afi_rready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%0h id %0d, expected none", afi_rdata, afi_rid);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("rdata", afi_rdata, e.data);
                chk("rid",   64'(afi_rid), 64'(e.id));
                chk("rlast", 64'(afi_rlast), 64'(e.last));
                chk("rresp", 64'(afi_rresp), 64'(e.resp));
            end
        end
    end

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id,
                           input logic [1:0] size, input logic [1:0] burst);
        int t;
        int q;
        q = int'(addr[11:3]);
        for (int b = 0; b <= int'(len); b++)
            exp_q.push_back('{pat((q + b) % 512), id, (b == int'(len)),
                              ((size != 2'b11) || (burst != 2'b01)) ? 2'b10 : 2'b00});
        @(posedge hclk); #1;
        afi_araddr  = addr;
        afi_arlen   = len;
        afi_arid    = id;
        afi_arsize  = size;
        afi_arburst = burst;
        afi_arvalid = 1'b1;
        t = 0;
        while (!afi_arready && t < 200) begin
            @(posedge hclk); #1;
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL ar_timeout: arready stayed 0, expected 1 within 200 cycles");
        end else begin
            @(posedge hclk); #1;
        end
        afi_arvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge hclk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge hclk);
        chk({name, "_rcount_end"}, 64'(afi_rcount), 64'd0);
        chk({name, "_rvalid_end"}, 64'(afi_rvalid), 64'd0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        chk("rst_rvalid",  64'(afi_rvalid), 64'd0);
        chk("rst_rlast",   64'(afi_rlast), 64'd0);
        chk("rst_rid",     64'(afi_rid), 64'd0);
        chk("rst_rresp",   64'(afi_rresp), 64'd0);
        chk("rst_rdata",   afi_rdata, 64'd0);
        chk("rst_rcount",  64'(afi_rcount), 64'd0);
        chk("rst_racount", 64'(afi_racount), 64'd0);
        chk("rst_arready", 64'(afi_arready), 64'd1);
        hrst = 1'b0;

        for (int i = 0; i < 512; i++) begin
            @(posedge hclk); #1;
            mem_we    = 1'b1;
            mem_waddr = 9'(i);
            mem_wdata = pat(i);
        end
        @(posedge hclk); #1;
        mem_we = 1'b0;

        // basic two-beat burst at QWORD 2
        send_ar(32'h10, 4'd1, 6'd5, 2'b11, 2'b01);
        @(negedge hclk);
        chk("t1_racount_1", 64'(afi_racount), 64'd1);
        @(negedge hclk);
        chk("t1_racount_0", 64'(afi_racount), 64'd0);
        drain("t1");

        // 16 beats with back-pressure
        afi_rready = 1'b0;
        send_ar(32'h100, 4'd15, 6'd9, 2'b11, 2'b01);
        repeat (30) @(negedge hclk);
        chk("t2_rcount_16", 64'(afi_rcount), 64'd16);
        chk("t2_rvalid",    64'(afi_rvalid), 64'd1);
        chk("t2_pending",   64'(exp_q.size()), 64'd16);
        afi_rready = 1'b1;
        drain("t2");

        // stall with five addresses
        rd_stall = 1'b1;
        for (int k = 0; k < 4; k++)
            send_ar(32'((40 + k) * 8), 4'd0, 6'(k + 1), 2'b11, 2'b01);
        @(negedge hclk);
        chk("t3_racount_4", 64'(afi_racount), 64'd4);
        chk("t3_arready_0", 64'(afi_arready), 64'd0);
        chk("t3_no_data",   64'(afi_rvalid), 64'd0);
        fork
            send_ar(32'(44 * 8), 4'd1, 6'd6, 2'b11, 2'b01);
            begin
                repeat (3) @(posedge hclk);
                #1 rd_stall = 1'b0;
            end
        join
        drain("t3");

        // wrap at memory end, then aliased upper bits with unaligned low bits
        send_ar(32'hFF8, 4'd1, 6'd7, 2'b11, 2'b01);
        drain("t4");
        send_ar(32'h8000_100B, 4'd0, 6'd33, 2'b11, 2'b01);
        drain("t4b");

        // error bursts
        send_ar(32'h20, 4'd3, 6'd3, 2'b10, 2'b01);
        drain("t5");
        send_ar(32'h40, 4'd0, 6'd63, 2'b11, 2'b10);
        drain("t5b");

        // reset in the middle of a burst with seven beats buffered
        afi_rready = 1'b0;
        send_ar(32'h0, 4'd15, 6'd2, 2'b11, 2'b01);
        t = 0;
        while (afi_rcount != 8'd7 && t < 100) begin
            @(negedge hclk);
            t++;
        end
        chk("t6_rcount_7", 64'(afi_rcount), 64'd7);
        exp_q.delete();
        hrst = 1'b1;
        @(negedge hclk);
        chk("t6_rvalid",  64'(afi_rvalid), 64'd0);
        chk("t6_rcount",  64'(afi_rcount), 64'd0);
        chk("t6_racount", 64'(afi_racount), 64'd0);
        chk("t6_arready", 64'(afi_arready), 64'd1);
        hrst = 1'b0;
        afi_rready = 1'b1;
        send_ar(32'h38, 4'd2, 6'd11, 2'b11, 2'b01);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahci_afi_rd_responder.md
Name: ahci_afi_rd_responder

Overview:
Synthesizable responder for the read channel of the Zynq AXI_HP (AFI) port. It accepts read-address bursts from the AHCI DMA engine and returns 64-bit data from an internal, backdoor-loaded system-memory model. It also produces the PL-side sideband counters that the DMA engine throttles on: rcount (read-data FIFO fill) and racount (address FIFO fill). It is used for in-fabric loopback and for hardware or simulation verification of the DMA read path without the PS.

Parameters:
MEM_ADDR_BITS, 9, QWORD address width of the memory model (512 x 64 bits).
ARQ_BITS, 2, log2 of address-FIFO depth (4 entries).
RQ_BITS, 7, log2 of read-data FIFO depth (128 QWORDs).

Ports:
hclk  input  1  AFI clock; all logic is on its rising edge.
hrst  input  1  Reset, synchronous, active-high.
afi_araddr  input  32  Burst byte address.
afi_arvalid  input  1  Address valid.
afi_arready  output  1  Address accepted when high together with arvalid.
afi_arid  input  6  Burst ID, returned on rid.
afi_arlen  input  4  Beats minus 1.
afi_arsize  input  2  Must be 2'b11 (8 bytes).
afi_arburst  input  2  Must be 2'b01 (INCR).
afi_rdata  output  64  Read data.
afi_rvalid  output  1  Data FIFO not empty.
afi_rready  input  1  Pop the data FIFO.
afi_rid  output  6  ID of the current beat.
afi_rlast  output  1  Last beat of the burst.
afi_rresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
afi_rcount  output  8  Data FIFO occupancy, 0..128.
afi_racount  output  3  Address FIFO occupancy, 0..4.
afi_rdissuecap1en  input  1  Ignored.
rd_stall  input  1  Test throttle; while high, no new burst is started.
mem_we  input  1  Backdoor write strobe.
mem_waddr  input  MEM_ADDR_BITS  Backdoor QWORD address.
mem_wdata  input  64  Backdoor data.

Behaviour:
- Reset (hrst=1), next edge: both FIFOs empty, engine in IDLE. Outputs become rvalid=0, rlast=0, rid=0, rresp=0, rdata=0, rcount=0, racount=0. afi_arready is 1 in the cycle after reset.
- Reset mid-burst drops all queued addresses and data. Memory contents are retained.
- Address FIFO:
  - afi_arready = !full.
  - Push stores {araddr[MEM_ADDR_BITS+2:3], arlen, arid, err}, where err = (arsize!=3 || arburst!=1).
  - araddr[2:0] is ignored (address aligned down). Upper address bits alias.
  - racount reflects the state after each edge. Simultaneous push and pop leave the count unchanged.
- Engine FSM:
  - IDLE to BURST when the address FIFO is not empty and rd_stall=0. This transition pops the FIFO and loads addr, beats_left=arlen, id, err.
  - BURST: issue one memory read per cycle only if rcount + inflight < 2^RQ_BITS; otherwise hold.
  - Address increments by 1 modulo 2^MEM_ADDR_BITS (wraps at the memory end; no 4 KB check).
  - After the beat with beats_left==0 is issued, return to IDLE. A queued address may start on the following cycle (one idle cycle between bursts is allowed).
- Memory is dual-port with a 1-cycle read latency. Data is pushed into the data FIFO tagged with {rlast, id, resp}.
  - A backdoor write and an engine read to the same address in the same cycle return the old data.
- err bursts still return exactly arlen+1 beats, with rresp=2'b10 on every beat. The data is the memory contents.
- Data FIFO:
  - First-word fall-through; rvalid=!empty. Pop when rvalid && rready. rready while empty has no effect.
  - rcount = occupancy after each edge. Simultaneous push and pop leave it unchanged.
  - Never overflows (guaranteed by the throttle). Data is never lost or reordered.
- Latency: arvalid accepted at edge N; earliest rvalid is at edge N+3 (FIFO, FSM, RAM).

Decomposition:
- Shared package: AFI_RESP_OKAY=2'b00, AFI_RESP_SLVERR=2'b10, AFI_BURST_INCR=2'b01, AFI_SIZE_64=2'b11.
- One natural sub-module: afi_sync_fifo, a parameterized width/depth single-clock FWFT FIFO with a count output. It is instantiated twice (address FIFO and data FIFO).

Test Plan:
- Preload mem[i]=i. araddr=0x10, arlen=1, arid=5 -> two beats 2 then 3; rlast on beat 2 only; rid=5; rresp=0; racount goes 1 then 0.
- arlen=15, rready=0 -> rcount rises to 16 and holds with no extra beats. Then rready=1 -> 16 beats of ordered data, rcount returns to 0.
- rd_stall=1, issue 5 addresses -> arready=0 after 4 accepted, racount=4. Release stall -> all 5 bursts complete in order.
- araddr=0xFF8 (QWORD 511), arlen=1 -> data mem[511], then mem[0].
- arsize=2, arlen=3 -> 4 beats, each with rresp=2'b10; rlast on the 4th.
- hrst asserted mid-burst with rcount=7 -> next cycle rvalid=0, rcount=0, racount=0, arready=1. A new burst afterwards returns the correct preloaded data.
